// File: rtl/venom_magazine_pkg.sv
// Shared types and helpers for the venom magazine block.
//   venom_state_t : per-channel FSM state (READY, HELD, EMPTY)
//   KEY_NONE      : fire keycode value meaning "channel has no fire key"
//   key_match     : true when either of the two reported keycodes equals key
package venom_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    HELD  = 2'd1,
    EMPTY = 2'd2
  } venom_state_t;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // A disabled key never matches, even against an idle (all-zero) keycode.
  function automatic logic key_match(input logic [15:0] keycode, input logic [7:0] key);
    return (key != KEY_NONE) && ((keycode[15:8] == key) || (keycode[7:0] == key));
  endfunction

endpackage

// File: rtl/venom_magazine_if.sv
// Bus between the keycode/pickup side and the projectile spawners / HUD.
//   frame_tick, keycode, fire_key, reload_req, auto_reload_en : into the magazine
//   fire, shots_used, empty, reloading                         : out of the magazine
// master = stimulus/controller side, slave = venom_magazine.
interface venom_magazine_if #(
  parameter int NUM_CH   = 2,
  parameter int MAG_SIZE = 3
);
  localparam int CNT_W = $clog2(MAG_SIZE + 1);

  logic                      frame_tick;
  logic [15:0]               keycode;
  logic [NUM_CH*8-1:0]       fire_key;
  logic [NUM_CH-1:0]         reload_req;
  logic                      auto_reload_en;
  logic [NUM_CH-1:0]         fire;
  logic [NUM_CH*CNT_W-1:0]   shots_used;
  logic [NUM_CH-1:0]         empty;
  logic [NUM_CH-1:0]         reloading;

  modport master (
    output frame_tick, keycode, fire_key, reload_req, auto_reload_en,
    input  fire, shots_used, empty, reloading
  );

  modport slave (
    input  frame_tick, keycode, fire_key, reload_req, auto_reload_en,
    output fire, shots_used, empty, reloading
  );

endinterface

// File: rtl/venom_channel.sv
// One player's magazine: fire-key edge qualification, shot counter and
// frame-counted auto reload timer.
//   Clk, Reset      : clock, synchronous active-high reset
//   frame_tick      : one pulse per video frame
//   keycode         : two simultaneous keycodes
//   fire_key        : this channel's fire keycode (KEY_NONE = disabled)
//   reload_req      : level reload request
//   auto_reload_en  : global enable for the timed reload
//   fire            : registered one-cycle fire pulse
//   shots_used      : shots consumed since last reload
//   empty           : magazine exhausted (channel in EMPTY)
//   reloading       : channel in EMPTY with auto reload enabled
module venom_channel
  import venom_pkg::*;
#(
  parameter int MAG_SIZE     = 3,
  parameter int RELOAD_TICKS = 60,
  localparam int CNT_W = $clog2(MAG_SIZE + 1),
  localparam int TMR_W = $clog2(RELOAD_TICKS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [15:0]      keycode,
  input  logic [7:0]       fire_key,
  input  logic             reload_req,
  input  logic             auto_reload_en,
  output logic             fire,
  output logic [CNT_W-1:0] shots_used,
  output logic             empty,
  output logic             reloading
);

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(MAG_SIZE);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(RELOAD_TICKS - 1);

  venom_state_t     state;
  logic [TMR_W-1:0] timer;
  logic             key_hit;
  logic             tick_en;

  assign key_hit = key_match(keycode, fire_key);
  assign tick_en = auto_reload_en && frame_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= READY;
      timer      <= '0;
      shots_used <= '0;
      fire       <= 1'b0;
      empty      <= 1'b0;
      reloading  <= 1'b0;
    end else begin
      fire <= 1'b0;
      case (state)
        READY: begin
          if (reload_req) begin
            shots_used <= '0;
            state      <= key_hit ? HELD : READY;
          end else if (key_hit) begin
            fire       <= 1'b1;
            // Saturate: READY is never entered full, this is a safety net.
            shots_used <= (shots_used == FULL) ? shots_used : shots_used + CNT_W'(1);
            state      <= HELD;
          end
        end
        HELD: begin
          if (reload_req) begin
            shots_used <= '0;
          end else if (!key_hit) begin
            if (shots_used == FULL) begin
              // Empty is flagged on key release, not on the last shot.
              state     <= EMPTY;
              timer     <= '0;
              empty     <= 1'b1;
              reloading <= auto_reload_en;
            end else begin
              state <= READY;
            end
          end
        end
        EMPTY: begin
          reloading <= auto_reload_en;
          // A tick coincident with reload_req is absorbed by the reload.
          if (reload_req || (tick_en && timer == LAST_TICK)) begin
            shots_used <= '0;
            timer      <= '0;
            empty      <= 1'b0;
            reloading  <= 1'b0;
            state      <= key_hit ? HELD : READY;
          end else if (tick_en) begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: rtl/venom_magazine.sv
// Multi-channel venom magazine: one venom_channel per player, vectors sliced
// and packed through the venom_magazine_if bus.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : slave side of venom_magazine_if (see interface for signals)
module venom_magazine
  import venom_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int MAG_SIZE     = 3,
  parameter int RELOAD_TICKS = 60,
  localparam int CNT_W = $clog2(MAG_SIZE + 1),
  localparam int TMR_W = $clog2(RELOAD_TICKS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  venom_magazine_if.slave  bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    venom_channel #(
      .MAG_SIZE     (MAG_SIZE),
      .RELOAD_TICKS (RELOAD_TICKS)
    ) u_ch (
      .Clk            (Clk),
      .Reset          (Reset),
      .frame_tick     (bus.frame_tick),
      .keycode        (bus.keycode),
      .fire_key       (bus.fire_key[i*8 +: 8]),
      .reload_req     (bus.reload_req[i]),
      .auto_reload_en (bus.auto_reload_en),
      .fire           (bus.fire[i]),
      .shots_used     (bus.shots_used[i*CNT_W +: CNT_W]),
      .empty          (bus.empty[i]),
      .reloading      (bus.reloading[i])
    );
  end

endmodule

// File: tb/tb_venom_magazine.sv
module tb_venom_magazine;
  localparam int NUM_CH = 2;
  localparam int MAG    = 3;
  localparam int RT     = 60;
  localparam int CNT_W  = $clog2(MAG + 1);

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  venom_magazine_if #(.NUM_CH(NUM_CH), .MAG_SIZE(MAG)) bus ();

  venom_magazine #(.NUM_CH(NUM_CH), .MAG_SIZE(MAG), .RELOAD_TICKS(RT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  // Reference: each player owns ammo count, a "finger still down" flag,
  // a "magazine dry" flag and a count of enabled frame ticks while dry.
  bit m_held[NUM_CH], m_dry[NUM_CH], m_fire[NUM_CH], m_rld[NUM_CH];
  int m_shots[NUM_CH], m_ticks[NUM_CH];

  function automatic void model_step(bit rst, logic [15:0] kc, logic [NUM_CH-1:0] rr,
                                     bit tk, bit en);
    for (int c = 0; c < NUM_CH; c++) begin
      logic [7:0] fk;
      bit hit, refill;
      fk = bus.fire_key[c*8 +: 8];
      hit = (fk != 8'h00) && (kc[15:8] == fk || kc[7:0] == fk);
      m_fire[c] = 0;
      if (rst) begin
        m_held[c] = 0; m_dry[c] = 0; m_shots[c] = 0; m_ticks[c] = 0;
      end else if (m_dry[c]) begin
        refill = rr[c] || (en && tk && m_ticks[c] + 1 == RT);
        if (refill) begin
          m_dry[c] = 0; m_shots[c] = 0; m_ticks[c] = 0; m_held[c] = hit;
        end else if (en && tk) m_ticks[c]++;
      end else if (m_held[c]) begin
        if (rr[c]) m_shots[c] = 0;
        else if (!hit) begin
          m_held[c] = 0;
          if (m_shots[c] == MAG) begin m_dry[c] = 1; m_ticks[c] = 0; end
        end
      end else begin
        if (rr[c]) begin m_shots[c] = 0; m_held[c] = hit; end
        else if (hit) begin m_fire[c] = 1; m_shots[c]++; m_held[c] = 1; end
      end
      m_rld[c] = !rst && m_dry[c] && en;
    end
  endfunction

  int fires0;

  task automatic cyc(input bit rst, input logic [15:0] kc, input logic [NUM_CH-1:0] rr,
                     input bit tk, input bit en);
    @(negedge Clk);
    Reset = rst; bus.keycode = kc; bus.reload_req = rr;
    bus.frame_tick = tk; bus.auto_reload_en = en;
    model_step(rst, kc, rr, tk, en);
    @(posedge Clk); #1;
    fires0 += int'(bus.fire[0]);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("fire%0d", c), int'(bus.fire[c]), int'(m_fire[c]));
      chk($sformatf("shots%0d", c), int'(bus.shots_used[c*CNT_W +: CNT_W]), m_shots[c]);
      chk($sformatf("empty%0d", c), int'(bus.empty[c]), int'(m_dry[c]));
      chk($sformatf("reloading%0d", c), int'(bus.reloading[c]), int'(m_rld[c]));
    end
  endtask

  task automatic tap(input logic [15:0] kc);
    cyc(0, kc, '0, 0, 0);
    cyc(0, 16'h0000, '0, 0, 0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(3, 0))
      0: return 8'h00;
      1: return 8'h1A;
      2: return 8'h2C;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    Reset = 1'b1;
    bus.keycode = '0; bus.reload_req = '0; bus.frame_tick = 0; bus.auto_reload_en = 0;
    bus.fire_key = {8'h2C, 8'h1A};
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    chk("reset_shots", int'(bus.shots_used), 0);

    // Three taps empty ch0; empty follows the third release; fourth tap is dead.
    fires0 = 0;
    for (int k = 0; k < 3; k++) tap(16'h001A);
    chk("empty_after3", int'(bus.empty[0]), 1);
    tap(16'h1A00);
    chk("fires_3taps", fires0, 3);

    // Auto reload with the enable dropped for 10 of the ticks.
    for (int t = 0; t < 70; t++) cyc(0, 0, '0, 1, !(t >= 30 && t < 40));
    chk("autoreload_shots", int'(bus.shots_used[CNT_W-1:0]), 0);
    chk("autoreload_empty", int'(bus.empty[0]), 0);

    // Long hold fires once.
    fires0 = 0;
    for (int t = 0; t < 50; t++) cyc(0, 16'h001A, '0, 0, 0);
    chk("hold_fires", fires0, 1);
    cyc(0, 0, '0, 0, 0);
    tap(16'h001A);
    // Reload with a coincident key hit: no fire, clears, then needs release.
    cyc(0, 16'h001A, 2'b01, 0, 0);
    cyc(0, 0, '0, 0, 0);
    fires0 = 0;
    tap(16'h001A);
    chk("fire_after_reload", fires0, 1);

    // Both channels on one keycode pair; disabled key never matches idle keycode.
    tap({8'h1A, 8'h2C});
    bus.fire_key[15:8] = 8'h00;
    tap(16'h0000);
    bus.fire_key[15:8] = 8'h2C;

    // Reset mid-reload restarts the full tick count.
    tap(16'h001A);
    for (int t = 0; t < 40; t++) cyc(0, 0, '0, 1, 1);
    cyc(1, 16'h001A, '0, 1, 1);
    chk("reset_empty", int'(bus.empty), 0);
    cyc(0, 16'h001A, '0, 0, 1);
    chk("fire_after_reset", int'(bus.fire[0]), 1);
    cyc(0, 0, '0, 0, 1);
    for (int k = 0; k < 2; k++) tap(16'h001A);
    for (int t = 0; t < RT - 1; t++) cyc(0, 0, '0, 1, 1);
    chk("still_empty_59", int'(bus.empty[0]), 1);
    cyc(0, 0, '0, 1, 1);
    chk("reload_at_60", int'(bus.empty[0]), 0);

    // Randomized traffic against the reference.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) bus.fire_key = {8'h1A, 8'h1A};
      cyc($urandom_range(299, 0) == 0, {pick(), pick()},
          NUM_CH'($urandom_range(15, 0) == 0 ? $urandom : 0),
          $urandom_range(1, 0) == 1, $urandom_range(7, 0) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
